// File: rtl/fu_uop_pipe_if.sv
// fu_uop_pipe_if: request, branch-update, datapath and response signals of the
// fixed-latency functional-unit shell. The master side is whoever issues uops and
// drives the datapath result. The slave side is the fu_uop_pipe shell itself.
interface fu_uop_pipe_if #(
    parameter int QDEPTH = 4,
    parameter int BR_W   = 20,
    parameter int META_W = 64,
    parameter int DATA_W = 65
);
    localparam int CNT_W = $clog2(QDEPTH + 1) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [BR_W-1:0]   req_bits_br_mask;
    logic [META_W-1:0] req_bits_meta;

    logic              kill;
    logic [BR_W-1:0]   brupdate_resolve_mask;
    logic [BR_W-1:0]   brupdate_mispredict_mask;

    logic [DATA_W-1:0] fu_data;
    logic              fu_fflags_valid;
    logic [4:0]        fu_fflags;

    logic              resp_valid;
    logic              resp_ready;
    logic [META_W-1:0] resp_bits_meta;
    logic [BR_W-1:0]   resp_bits_br_mask;
    logic [DATA_W-1:0] resp_bits_data;
    logic              resp_bits_fflags_valid;
    logic [4:0]        resp_bits_fflags;

    logic [CNT_W-1:0]  count;

    modport master (
        output req_valid, req_bits_br_mask, req_bits_meta,
        output kill, brupdate_resolve_mask, brupdate_mispredict_mask,
        output fu_data, fu_fflags_valid, fu_fflags,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_bits_meta, resp_bits_br_mask, resp_bits_data,
        input  resp_bits_fflags_valid, resp_bits_fflags,
        input  count
    );

    modport slave (
        input  req_valid, req_bits_br_mask, req_bits_meta,
        input  kill, brupdate_resolve_mask, brupdate_mispredict_mask,
        input  fu_data, fu_fflags_valid, fu_fflags,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_bits_meta, resp_bits_br_mask, resp_bits_data,
        output resp_bits_fflags_valid, resp_bits_fflags,
        output count
    );
endinterface

// File: rtl/fu_uop_pipe.sv
// fu_uop_pipe: uop-tracking shell around a fixed-latency datapath (e.g. the FPU).
// Uop metadata and branch masks ride alongside the external datapath for LATENCY
// cycles, are subject to kill/resolve/mispredict in every stage, and the result is
// captured into a small response queue drained with valid/ready. Requests are only
// accepted while in-flight plus queued uops are below QDEPTH, so a push can never
// find the queue full.
// Optional feature: define FU_PIPE_BYPASS_EN to forward a finishing uop straight to
// the response port when the queue is empty and the consumer is ready, saving a cycle.
module fu_uop_pipe #(
    parameter int LATENCY = 4,
    parameter int QDEPTH  = 4,
    parameter int BR_W    = 20,
    parameter int META_W  = 64,
    parameter int DATA_W  = 65
) (
    input  logic         clock,
    input  logic         reset_n,
    fu_uop_pipe_if.slave io
);

    localparam int CNT_W = $clog2(QDEPTH + 1) + 1;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

`ifdef FU_PIPE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    // Pipeline stage state (index 0 is stage 1, index LATENCY-1 is the final stage)
    logic [LATENCY-1:0] r_stgValid;
    logic [BR_W-1:0]    r_stgMask [LATENCY];
    logic [META_W-1:0]  r_stgMeta [LATENCY];

    // Response queue state
    logic [QDEPTH-1:0]  r_qLive;
    logic [QDEPTH-1:0]  r_qFflagsValid;
    logic [BR_W-1:0]    r_qMask   [QDEPTH];
    logic [META_W-1:0]  r_qMeta   [QDEPTH];
    logic [DATA_W-1:0]  r_qData   [QDEPTH];
    logic [4:0]         r_qFflags [QDEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_qCount;

    logic               w_fire;
    logic               w_reqReady;
    logic               w_reqMisp;
    logic [LATENCY-1:0] w_stgLive;
    logic               w_lastLive;
    logic               w_qEmpty;
    logic [BR_W-1:0]    w_headMask;
    logic               w_headValid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_inflight;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A stage survives into the next one unless flushed or its mask hits a mispredict
    always_comb begin
        w_stgLive = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_stgLive[i] = r_stgValid[i] & ~io.kill
                         & ~(|(io.brupdate_mispredict_mask & r_stgMask[i]));
        end
    end

    // Credit accounting: every valid stage plus every queued entry holds one credit
    always_comb begin
        w_inflight = r_qCount;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_stgValid[i]);
        end
    end

    assign w_reqReady  = (w_inflight < CNT_W'(QDEPTH));
    assign w_fire      = io.req_valid & w_reqReady;
    assign w_reqMisp   = |(io.brupdate_mispredict_mask & io.req_bits_br_mask);
    assign w_lastLive  = w_stgLive[LATENCY-1];
    assign w_qEmpty    = (r_qCount == '0);
    assign w_headMask  = r_qMask[r_head];
    assign w_headValid = ~w_qEmpty & r_qLive[r_head] & ~io.kill
                       & ~(|(io.brupdate_mispredict_mask & w_headMask));
    assign w_bypass    = BYPASS_EN & w_lastLive & w_qEmpty & io.resp_ready;
    assign w_push      = w_lastLive & ~w_bypass;
    assign w_pop       = ~w_qEmpty & ~io.kill
                       & ((w_headValid & io.resp_ready) | ~r_qLive[r_head]);

    assign io.req_ready = w_reqReady;
    assign io.count     = w_inflight;

    // Response port shows either the forwarded final stage or the queue head
    always_comb begin
        io.resp_valid = w_headValid | w_bypass;
        if (w_bypass) begin
            io.resp_bits_meta         = r_stgMeta[LATENCY-1];
            io.resp_bits_br_mask      = r_stgMask[LATENCY-1] & ~io.brupdate_resolve_mask;
            io.resp_bits_data         = io.fu_data;
            io.resp_bits_fflags_valid = io.fu_fflags_valid;
            io.resp_bits_fflags       = io.fu_fflags;
        end else begin
            io.resp_bits_meta         = r_qMeta[r_head];
            io.resp_bits_br_mask      = w_headMask & ~io.brupdate_resolve_mask;
            io.resp_bits_data         = r_qData[r_head];
            io.resp_bits_fflags_valid = r_qFflagsValid[r_head];
            io.resp_bits_fflags       = r_qFflags[r_head];
        end
    end

    // Control state: stage valids, queue liveness, pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stgValid <= '0;
            r_qLive    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_qCount   <= '0;
        end else begin
            r_stgValid[0] <= w_fire & ~io.kill & ~w_reqMisp;
            for (int i = 1; i < LATENCY; i++) begin
                r_stgValid[i] <= w_stgLive[i-1];
            end
            if (io.kill) begin
                r_qLive  <= '0;
                r_head   <= '0;
                r_tail   <= '0;
                r_qCount <= '0;
            end else begin
                for (int q = 0; q < QDEPTH; q++) begin
                    if (|(io.brupdate_mispredict_mask & r_qMask[q])) begin
                        r_qLive[q] <= 1'b0;
                    end
                end
                if (w_push) begin
                    r_qLive[r_tail] <= 1'b1;
                    r_tail          <= ptrNext(r_tail);
                end
                if (w_pop) begin
                    r_head <= ptrNext(r_head);
                end
                r_qCount <= r_qCount + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Payload state: masks shed resolved bits every cycle, metadata and data just move
    always_ff @(posedge clock) begin
        r_stgMask[0] <= io.req_bits_br_mask & ~io.brupdate_resolve_mask;
        r_stgMeta[0] <= io.req_bits_meta;
        for (int i = 1; i < LATENCY; i++) begin
            r_stgMask[i] <= r_stgMask[i-1] & ~io.brupdate_resolve_mask;
            r_stgMeta[i] <= r_stgMeta[i-1];
        end
        for (int q = 0; q < QDEPTH; q++) begin
            r_qMask[q] <= r_qMask[q] & ~io.brupdate_resolve_mask;
        end
        if (w_push) begin
            r_qMask[r_tail]        <= r_stgMask[LATENCY-1] & ~io.brupdate_resolve_mask;
            r_qMeta[r_tail]        <= r_stgMeta[LATENCY-1];
            r_qData[r_tail]        <= io.fu_data;
            r_qFflagsValid[r_tail] <= io.fu_fflags_valid;
            r_qFflags[r_tail]      <= io.fu_fflags;
        end
    end

endmodule

// File: tb/tb_fu_uop_pipe.sv
// tb_fu_uop_pipe: scoreboard bench for fu_uop_pipe. Requests that fire are pushed
// into an expectation queue; branch kills and flushes remove them, resolves clear
// their mask bits, and every accepted response pops and compares the head.
// The external datapath is modelled by a delay line that presents each fired
// request's data exactly LATENCY cycles after it fired.
module tb_fu_uop_pipe;

    localparam int LATENCY = 4;
    localparam int QDEPTH  = 4;
    localparam int BR_W    = 20;
    localparam int META_W  = 64;
    localparam int DATA_W  = 65;
    localparam int CNT_W   = $clog2(QDEPTH + 1) + 1;
`ifdef FU_PIPE_BYPASS_EN
    localparam int RESP_LAT = LATENCY;
`else
    localparam int RESP_LAT = LATENCY + 1;
`endif

    typedef struct packed {
        logic [BR_W-1:0]   mask;
        logic [META_W-1:0] meta;
        logic [DATA_W-1:0] data;
        logic              ffv;
        logic [4:0]        ff;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fired = 0;
    int   fireCyc = 0;
    int   respSeen = 0;
    int   lastRespCyc = 0;
    logic [BR_W-1:0] lastRespMask;

    logic [DATA_W-1:0] reqData;
    logic              reqFfv;
    logic [4:0]        reqFf;
    logic [DATA_W-1:0] dlData [LATENCY];
    logic              dlFfv  [LATENCY];
    logic [4:0]        dlFf   [LATENCY];

    fu_uop_pipe_if #(.QDEPTH(QDEPTH), .BR_W(BR_W), .META_W(META_W), .DATA_W(DATA_W)) io ();

    fu_uop_pipe #(
        .LATENCY(LATENCY), .QDEPTH(QDEPTH), .BR_W(BR_W), .META_W(META_W), .DATA_W(DATA_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io)
    );

    always #5 clock = ~clock;

    task automatic setIdle();
        io.req_valid                = 1'b0;
        io.req_bits_br_mask         = '0;
        io.req_bits_meta            = '0;
        io.kill                     = 1'b0;
        io.brupdate_resolve_mask    = '0;
        io.brupdate_mispredict_mask = '0;
        io.resp_ready               = 1'b1;
        reqData                     = '0;
        reqFfv                      = 1'b0;
        reqFf                       = '0;
    endtask

    task automatic clearModel();
        sb.delete();
        for (int i = 0; i < LATENCY; i++) begin
            dlData[i] = '0;
            dlFfv[i]  = 1'b0;
            dlFf[i]   = '0;
        end
        io.fu_data         = '0;
        io.fu_fflags_valid = 1'b0;
        io.fu_fflags       = '0;
    endtask

    // One clock cycle: observe at the falling edge, update the model, then advance
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (io.kill) begin
            checks++;
            if (io.resp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL kill_resp_valid actual=%0b required=0", io.resp_valid);
            end
            sb.delete();
        end else begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (|(sb[i].mask & io.brupdate_mispredict_mask)) sb.delete(i);
            end
        end
        if (io.resp_valid === 1'b1 && io.resp_ready === 1'b1) begin
            respSeen++;
            lastRespCyc  = cyc;
            lastRespMask = io.resp_bits_br_mask;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_resp actual meta=%0h required=no response",
                         io.resp_bits_meta);
            end else begin
                e = sb.pop_front();
                if (io.resp_bits_meta !== e.meta || io.resp_bits_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL resp_payload actual meta=%0h data=%0h required meta=%0h data=%0h",
                             io.resp_bits_meta, io.resp_bits_data, e.meta, e.data);
                end
                checks++;
                if (io.resp_bits_br_mask !== (e.mask & ~io.brupdate_resolve_mask) ||
                    io.resp_bits_fflags_valid !== e.ffv || io.resp_bits_fflags !== e.ff) begin
                    errors++;
                    $display("[TB] FAIL resp_mask_flags actual mask=%0h fv=%0b ff=%0h required mask=%0h fv=%0b ff=%0h",
                             io.resp_bits_br_mask, io.resp_bits_fflags_valid, io.resp_bits_fflags,
                             e.mask & ~io.brupdate_resolve_mask, e.ffv, e.ff);
                end
            end
        end
        for (int i = 0; i < sb.size(); i++) begin
            e = sb[i];
            e.mask = e.mask & ~io.brupdate_resolve_mask;
            sb[i] = e;
        end
        for (int i = LATENCY - 1; i > 0; i--) begin
            dlData[i] = dlData[i-1];
            dlFfv[i]  = dlFfv[i-1];
            dlFf[i]   = dlFf[i-1];
        end
        if (io.req_valid === 1'b1 && io.req_ready === 1'b1) begin
            fired++;
            fireCyc   = cyc;
            dlData[0] = reqData;
            dlFfv[0]  = reqFfv;
            dlFf[0]   = reqFf;
            if (!io.kill && !(|(io.req_bits_br_mask & io.brupdate_mispredict_mask))) begin
                e.mask = io.req_bits_br_mask & ~io.brupdate_resolve_mask;
                e.meta = io.req_bits_meta;
                e.data = reqData;
                e.ffv  = reqFfv;
                e.ff   = reqFf;
                sb.push_back(e);
            end
        end else begin
            dlData[0] = '0;
            dlFfv[0]  = 1'b0;
            dlFf[0]   = '0;
        end
        @(posedge clock);
        cyc++;
        #1;
        io.fu_data         = dlData[LATENCY-1];
        io.fu_fflags_valid = dlFfv[LATENCY-1];
        io.fu_fflags       = dlFf[LATENCY-1];
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        setIdle();
        clearModel();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (io.resp_valid !== 1'b0 || io.req_ready !== 1'b1 || io.count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs actual valid=%0b ready=%0b count=%0d required valid=0 ready=1 count=0",
                     io.resp_valid, io.req_ready, io.count);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (io.req_ready !== 1'b1 || io.count !== '0 || io.resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle actual valid=%0b ready=%0b count=%0d required valid=0 ready=1 count=0",
                     io.resp_valid, io.req_ready, io.count);
        end
    endtask

    task automatic test_single();
        int base = respSeen;
        setIdle();
        io.req_valid     = 1'b1;
        io.req_bits_meta = 64'h1234;
        reqData          = 65'h0_3FF0_0000_0000_0000;
        tick();
        io.req_valid = 1'b0;
        checks++;
        if (io.count !== CNT_W'(1)) begin
            errors++;
            $display("[TB] FAIL single_count actual=%0d required=1", io.count);
        end
        for (int i = 0; i < 12 && respSeen == base; i++) tick();
        checks++;
        if (respSeen != base + 1) begin
            errors++;
            $display("[TB] FAIL single_resp_count actual=%0d required=1", respSeen - base);
        end
        checks++;
        if (lastRespCyc - fireCyc != RESP_LAT) begin
            errors++;
            $display("[TB] FAIL single_latency actual=%0d required=%0d", lastRespCyc - fireCyc, RESP_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int baseFired = fired;
        int baseResp  = respSeen;
        setIdle();
        io.resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io.req_valid     = 1'b1;
            io.req_bits_meta = META_W'(64'h100 + i);
            reqData          = {1'b0, 64'hA5A5_0000_0000_0000 | 64'(i)};
            reqFfv           = i[0];
            reqFf            = 5'(i + 3);
            tick();
        end
        io.req_valid = 1'b0;
        checks++;
        if (fired - baseFired != QDEPTH) begin
            errors++;
            $display("[TB] FAIL b2b_accepts actual=%0d required=%0d", fired - baseFired, QDEPTH);
        end
        checks++;
        if (io.req_ready !== 1'b0 || io.count !== CNT_W'(QDEPTH)) begin
            errors++;
            $display("[TB] FAIL b2b_full actual ready=%0b count=%0d required ready=0 count=%0d",
                     io.req_ready, io.count, QDEPTH);
        end
        io.resp_ready = 1'b1;
        for (int i = 0; i < 20 && respSeen < baseResp + QDEPTH; i++) tick();
        checks++;
        if (respSeen - baseResp != QDEPTH) begin
            errors++;
            $display("[TB] FAIL b2b_responses actual=%0d required=%0d", respSeen - baseResp, QDEPTH);
        end
        checks++;
        if (io.req_ready !== 1'b1 || io.count !== '0) begin
            errors++;
            $display("[TB] FAIL b2b_drained actual ready=%0b count=%0d required ready=1 count=0",
                     io.req_ready, io.count);
        end
    endtask

    task automatic test_mispredict();
        int base = respSeen;
        setIdle();
        io.req_valid        = 1'b1;
        io.req_bits_meta    = 64'h77;
        io.req_bits_br_mask = 20'h00004;
        reqData             = 65'h77;
        tick();
        setIdle();
        tick();
        io.brupdate_mispredict_mask = 20'h00004;
        tick();
        io.brupdate_mispredict_mask = '0;
        checks++;
        if (io.count !== '0 || io.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misp_credit actual count=%0d ready=%0b required count=0 ready=1",
                     io.count, io.req_ready);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (respSeen != base) begin
            errors++;
            $display("[TB] FAIL misp_no_resp actual=%0d required=0", respSeen - base);
        end
    endtask

    task automatic test_resolve();
        int base = respSeen;
        setIdle();
        io.resp_ready       = 1'b0;
        io.req_valid        = 1'b1;
        io.req_bits_meta    = 64'hA1;
        io.req_bits_br_mask = 20'h00001;
        reqData             = 65'h1_0000_0000_0000_00A1;
        tick();
        io.req_bits_meta    = 64'hA2;
        io.req_bits_br_mask = 20'h00002;
        reqData             = 65'h1_0000_0000_0000_00A2;
        tick();
        io.req_valid        = 1'b0;
        io.req_bits_br_mask = '0;
        for (int i = 0; i < LATENCY + 2; i++) tick();
        checks++;
        if (io.count !== CNT_W'(2)) begin
            errors++;
            $display("[TB] FAIL resolve_queued actual=%0d required=2", io.count);
        end
        io.brupdate_resolve_mask = 20'h00001;
        tick();
        io.brupdate_resolve_mask    = '0;
        io.brupdate_mispredict_mask = 20'h00002;
        tick();
        io.brupdate_mispredict_mask = '0;
        io.resp_ready               = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (respSeen - base != 1 || lastRespMask !== '0) begin
            errors++;
            $display("[TB] FAIL resolve_result actual resps=%0d mask=%0h required resps=1 mask=0",
                     respSeen - base, lastRespMask);
        end
        checks++;
        if (sb.size() != 0 || io.count !== '0) begin
            errors++;
            $display("[TB] FAIL resolve_drain actual pending=%0d count=%0d required pending=0 count=0",
                     sb.size(), io.count);
        end
    endtask

    task automatic test_kill();
        int base;
        setIdle();
        io.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            io.req_valid     = 1'b1;
            io.req_bits_meta = META_W'(64'hC0 + i);
            reqData          = 65'(64'hC0 + i);
            tick();
        end
        io.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 2; i++) begin
            io.req_valid     = 1'b1;
            io.req_bits_meta = META_W'(64'hD0 + i);
            reqData          = 65'(64'hD0 + i);
            tick();
        end
        io.req_valid = 1'b0;
        checks++;
        if (io.count !== CNT_W'(4)) begin
            errors++;
            $display("[TB] FAIL kill_setup_count actual=%0d required=4", io.count);
        end
        base          = respSeen;
        io.resp_ready = 1'b1;
        io.kill       = 1'b1;
        tick();
        io.kill = 1'b0;
        checks++;
        if (io.count !== '0 || io.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL kill_count actual count=%0d ready=%0b required count=0 ready=1",
                     io.count, io.req_ready);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (respSeen != base) begin
            errors++;
            $display("[TB] FAIL kill_no_resp actual=%0d required=0", respSeen - base);
        end
    endtask

    task automatic test_async_reset();
        int base;
        setIdle();
        io.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            io.req_valid     = 1'b1;
            io.req_bits_meta = META_W'(64'hE0 + i);
            reqData          = 65'(64'hE0 + i);
            tick();
        end
        io.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (io.resp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre_valid actual=%0b required=1", io.resp_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (io.resp_valid !== 1'b0 || io.req_ready !== 1'b1 || io.count !== '0) begin
            errors++;
            $display("[TB] FAIL areset_immediate actual valid=%0b ready=%0b count=%0d required valid=0 ready=1 count=0",
                     io.resp_valid, io.req_ready, io.count);
        end
        clearModel();
        tick();
        #2 reset_n = 1'b1;
        base          = respSeen;
        io.resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (respSeen != base) begin
            errors++;
            $display("[TB] FAIL areset_no_resp actual=%0d required=0", respSeen - base);
        end
        io.req_valid     = 1'b1;
        io.req_bits_meta = 64'h55;
        reqData          = 65'h1_2345_6789_ABCD_EF01;
        reqFfv           = 1'b1;
        reqFf            = 5'h11;
        tick();
        io.req_valid = 1'b0;
        for (int i = 0; i < 12 && respSeen == base; i++) tick();
        checks++;
        if (respSeen != base + 1 || lastRespCyc - fireCyc != RESP_LAT) begin
            errors++;
            $display("[TB] FAIL areset_fresh_req actual resps=%0d lat=%0d required resps=1 lat=%0d",
                     respSeen - base, lastRespCyc - fireCyc, RESP_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mispredict();
        test_resolve();
        test_kill();
        test_async_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL final_pending actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
